// File: rtl/state_shift_engine.sv
// state_shift_engine: self-sequencing ASCON state register.
// Holds COL_SIZE words of WORD_SIZE bits and runs complete serial passes over
// every word. Each cycle moves STEP_1 bits (mode = 1) or STEP_D bits (mode = 0)
// per word. New bits enter at the MSB and old bits leave at the LSB. The final
// cycle of a pass moves only the remainder L, so that exactly WORD_SIZE bits
// pass through each word.
// Optional feature: define STATE_SHIFT_ZEROIZE_EN to add the zeroize input.
// zeroize clears the state, the FSM and the cycle counter at any edge.
module state_shift_engine #(
    parameter int COL_SIZE  = 5,
    parameter int WORD_SIZE = 64,
    parameter int PAR       = 3,
    parameter int D         = 1,
    localparam int STEP_D   = (((D + 1) * PAR) < WORD_SIZE) ? ((D + 1) * PAR) : WORD_SIZE,
    localparam int STEP_1   = (PAR < WORD_SIZE) ? PAR : WORD_SIZE,
    localparam int N_1      = (WORD_SIZE + STEP_1 - 1) / STEP_1,
    localparam int N_D      = (WORD_SIZE + STEP_D - 1) / STEP_D,
    localparam int N_MAX    = (N_1 > N_D) ? N_1 : N_D,
    localparam int CNT_W    = $clog2(N_MAX) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_en,
    input  logic [COL_SIZE*WORD_SIZE-1:0]  data_in,
    input  logic                           start,
    input  logic                           mode,
    input  logic                           abort,
`ifdef STATE_SHIFT_ZEROIZE_EN
    input  logic                           zeroize,
`endif
    input  logic [COL_SIZE*STEP_1-1:0]     in_shift_1,
    input  logic [COL_SIZE*STEP_D-1:0]     in_shift_d,
    output logic [COL_SIZE*STEP_D-1:0]     out_shift,
    output logic [COL_SIZE*WORD_SIZE-1:0]  data_out,
    output logic                           busy,
    output logic                           last_cycle,
    output logic                           done,
    output logic [CNT_W-1:0]               cycle_cnt
);

    // Size of the short final step for each mode.
    localparam int L_1 = WORD_SIZE - (N_1 - 1) * STEP_1;
    localparam int L_D = WORD_SIZE - (N_D - 1) * STEP_D;

    // Counter value of the final shift cycle for each mode.
    localparam logic [CNT_W-1:0] LAST_1 = CNT_W'(N_1 - 1);
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(N_D - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    fsm_t                  fsm_reg;
    fsm_t                  fsm_next;
    logic [WORD_SIZE-1:0]  words_reg  [COL_SIZE];
    logic [WORD_SIZE-1:0]  words_next [COL_SIZE];
    logic [CNT_W-1:0]      cnt_reg;
    logic                  mode_reg;
    logic                  zero_req;
    logic                  at_last;

`ifdef STATE_SHIFT_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // The final cycle of a pass is reached when the counter hits N-1 of the latched mode.
    assign at_last = (cnt_reg == (mode_reg ? LAST_1 : LAST_D));

    // This function shifts AMT bits of INS into the MSB end of WORD and drops AMT bits from the LSB end.
    // The concatenate-and-shift form is valid for any AMT from 1 to WORD_SIZE.
    // It also covers the full-word replacement that happens when N == 1.
    function automatic logic [WORD_SIZE-1:0] shift_in(
        input logic [WORD_SIZE-1:0] word,
        input logic [WORD_SIZE-1:0] ins,
        input int                   amt
    );
        return WORD_SIZE'({ins, word} >> amt);
    endfunction

    // Build the candidate next value and the outputs for each word.
    generate
        for (genvar gi = 0; gi < COL_SIZE; gi++) begin : g_word
            logic [WORD_SIZE-1:0] in1_ext;
            logic [WORD_SIZE-1:0] ind_ext;

            assign in1_ext = WORD_SIZE'(in_shift_1[gi*STEP_1 +: STEP_1]);
            assign ind_ext = WORD_SIZE'(in_shift_d[gi*STEP_D +: STEP_D]);

            // The step size is fixed by the latched mode and by whether this is the final cycle.
            assign words_next[gi] = mode_reg
                ? (at_last ? shift_in(words_reg[gi], in1_ext, L_1)
                           : shift_in(words_reg[gi], in1_ext, STEP_1))
                : (at_last ? shift_in(words_reg[gi], ind_ext, L_D)
                           : shift_in(words_reg[gi], ind_ext, STEP_D));

            assign out_shift[gi*STEP_D +: STEP_D]       = words_reg[gi][STEP_D-1:0];
            assign data_out[gi*WORD_SIZE +: WORD_SIZE]  = words_reg[gi];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg <= ST_IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // Next-state logic and output decode.
    // abort beats the last-cycle exit, and zeroize beats everything.
    always_comb begin
        fsm_next   = fsm_reg;
        busy       = 1'b0;
        done       = 1'b0;
        last_cycle = 1'b0;
        cycle_cnt  = cnt_reg;
        case (fsm_reg)
            ST_IDLE: begin
                if (start) begin
                    fsm_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy       = 1'b1;
                last_cycle = at_last;
                if (abort) begin
                    fsm_next = ST_IDLE;
                end else if (at_last) begin
                    fsm_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                fsm_next = ST_IDLE;
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase
        if (zero_req) begin
            fsm_next = ST_IDLE;
        end
    end

    // Pass counter and latched mode.
    // The counter freezes on abort and holds N through DONE and IDLE until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            mode_reg <= 1'b1;
        end else if (zero_req) begin
            cnt_reg  <= '0;
        end else begin
            case (fsm_reg)
                ST_IDLE: begin
                    if (start) begin
                        mode_reg <= mode;
                        cnt_reg  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!abort) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State words: parallel load in IDLE and serial shift in SHIFT.
    // A load and a start in the same cycle both take effect.
    // As a result, the first shift operates on the newly loaded data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COL_SIZE; i++) begin
                words_reg[i] <= '0;
            end
        end else if (zero_req) begin
            for (int i = 0; i < COL_SIZE; i++) begin
                words_reg[i] <= '0;
            end
        end else begin
            case (fsm_reg)
                ST_IDLE: begin
                    if (load_en) begin
                        for (int i = 0; i < COL_SIZE; i++) begin
                            words_reg[i] <= data_in[i*WORD_SIZE +: WORD_SIZE];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!abort) begin
                        for (int i = 0; i < COL_SIZE; i++) begin
                            words_reg[i] <= words_next[i];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_shift_engine.sv
// Directed testbench for state_shift_engine with the default parameters.
// N_D = 11 (last step 4) and N_1 = 22 (last step 1).
module tb_state_shift_engine;

    localparam int COL = 5;
    localparam int W   = 64;
    localparam int S1  = 3;
    localparam int SD  = 6;
    localparam int CW  = 6;

    localparam logic [W-1:0] PAT_X = 64'h0123456789ABCDEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_en;
    logic [COL*W-1:0]  data_in;
    logic              start;
    logic              mode;
    logic              abort;
`ifdef STATE_SHIFT_ZEROIZE_EN
    logic              zeroize;
`endif
    logic [COL*S1-1:0] in_shift_1;
    logic [COL*SD-1:0] in_shift_d;
    logic [COL*SD-1:0] out_shift;
    logic [COL*W-1:0]  data_out;
    logic              busy;
    logic              last_cycle;
    logic              done;
    logic [CW-1:0]     cycle_cnt;

    logic              lb_1;
    logic              lb_d;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Loopback feeds each word's outgoing low bits back in, which turns a full pass into a rotation.
    always_comb begin
        in_shift_d = lb_d ? out_shift : '0;
        in_shift_1 = '0;
        if (lb_1) begin
            for (int i = 0; i < COL; i++) begin
                in_shift_1[i*S1 +: S1] = out_shift[i*SD +: S1];
            end
        end
    end

    state_shift_engine dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .data_in    (data_in),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
`ifdef STATE_SHIFT_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .in_shift_1 (in_shift_1),
        .in_shift_d (in_shift_d),
        .out_shift  (out_shift),
        .data_out   (data_out),
        .busy       (busy),
        .last_cycle (last_cycle),
        .done       (done),
        .cycle_cnt  (cycle_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // This task loads every word with w and starts a pass in the same cycle.
    // On return the bench is in cycle 1 of the pass.
    task automatic start_pass(input logic [W-1:0] w, input logic m);
        data_in = {COL{w}};
        load_en = 1'b1;
        start   = 1'b1;
        mode    = m;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (last_cycle !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", last_cycle); end
        vectors++; if (cycle_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); end
        rst = 1'b0;
        tick();
        $display("test_reset complete");
    endtask

    task automatic test_rotate_masked();
        lb_d = 1'b1;
        start_pass(PAT_X, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rotm_busy c%0d: got %b want 1", k, busy); end
            vectors++; if (last_cycle !== (k == 11)) begin errors++; $display("FAIL rotm_last c%0d: got %b want %b", k, last_cycle, (k == 11)); end
            vectors++; if (cycle_cnt !== CW'(k - 1)) begin errors++; $display("FAIL rotm_cnt c%0d: got %0d want %0d", k, cycle_cnt, k - 1); end
            tick();
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL rotm_done: got %b want 1", done); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rotm_busy_end: got %b want 0", busy); end
        vectors++; if (data_out !== {COL{PAT_X}}) begin errors++; $display("FAIL rotm_data: got %h want %h", data_out, {COL{PAT_X}}); end
        vectors++; if (cycle_cnt !== 6'd11) begin errors++; $display("FAIL rotm_cnt_end: got %0d want 11", cycle_cnt); end
        tick();
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rotm_done_pulse: got %b want 0", done); end
        vectors++; if (cycle_cnt !== 6'd11) begin errors++; $display("FAIL rotm_cnt_hold: got %0d want 11", cycle_cnt); end
        lb_d = 1'b0;
        $display("test_rotate_masked complete");
    endtask

    task automatic test_clear_unmasked();
        start_pass(64'hFFFFFFFFFFFFFFFF, 1'b1);
        for (int k = 1; k <= 22; k++) begin
            vectors++; if (last_cycle !== (k == 22)) begin errors++; $display("FAIL clr_last c%0d: got %b want %b", k, last_cycle, (k == 22)); end
            if (k == 22) begin
                vectors++; if (data_out !== {COL{64'h1}}) begin errors++; $display("FAIL clr_before_last: got %h want %h", data_out, {COL{64'h1}}); end
            end
            tick();
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL clr_done: got %b want 1", done); end
        vectors++; if (data_out !== '0) begin errors++; $display("FAIL clr_data: got %h want 0", data_out); end
        vectors++; if (cycle_cnt !== 6'd22) begin errors++; $display("FAIL clr_cnt: got %0d want 22", cycle_cnt); end
        tick();
        $display("test_clear_unmasked complete");
    endtask

    task automatic test_rotate_unmasked_distinct();
        logic [COL*W-1:0] init;
        init = {64'h5A5A5A5AA5A5A5A5, 64'h8000000000000001, 64'hDEADBEEFCAFEF00D,
                64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        lb_1    = 1'b1;
        data_in = init;
        load_en = 1'b1;
        start   = 1'b1;
        mode    = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        tick();
        vectors++; if (data_out[3*W +: W] !== 64'h3000000000000000) begin errors++; $display("FAIL rotu_word3: got %h want 3000000000000000", data_out[3*W +: W]); end
        for (int k = 2; k <= 22; k++) begin
            tick();
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL rotu_done: got %b want 1", done); end
        vectors++; if (data_out !== init) begin errors++; $display("FAIL rotu_data: got %h want %h", data_out, init); end
        vectors++; if (cycle_cnt !== 6'd22) begin errors++; $display("FAIL rotu_cnt: got %0d want 22", cycle_cnt); end
        tick();
        lb_1 = 1'b0;
        $display("test_rotate_unmasked_distinct complete");
    endtask

    task automatic test_ignore_busy();
        lb_d = 1'b1;
        start_pass(PAT_X, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            if (k == 3) begin
                data_in = {COL{64'hAAAAAAAAAAAAAAAA}};
                load_en = 1'b1;
                start   = 1'b1;
            end else begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            tick();
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", done); end
        vectors++; if (data_out !== {COL{PAT_X}}) begin errors++; $display("FAIL ign_data: got %h want %h", data_out, {COL{PAT_X}}); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_second c%0d: got %b want 0", k, busy); end
        end
        lb_d = 1'b0;
        $display("test_ignore_busy complete");
    endtask

    task automatic test_abort();
        lb_d = 1'b1;
        start_pass(PAT_X, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        vectors++; if (cycle_cnt !== 6'd5) begin errors++; $display("FAIL abort_cnt: got %0d want 5", cycle_cnt); end
        vectors++; if (data_out !== {COL{64'h26AF37BC048D159E}}) begin errors++; $display("FAIL abort_data: got %h want %h", data_out, {COL{64'h26AF37BC048D159E}}); end
        tick();
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_late: got %b want 0", done); end
        lb_d = 1'b0;
        $display("test_abort complete");
    endtask

    task automatic test_abort_last();
        lb_d = 1'b1;
        start_pass(PAT_X, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
        end
        vectors++; if (last_cycle !== 1'b1) begin errors++; $display("FAIL abl_last: got %b want 1", last_cycle); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abl_done: got %b want 0", done); end
        vectors++; if (cycle_cnt !== 6'd10) begin errors++; $display("FAIL abl_cnt: got %0d want 10", cycle_cnt); end
        vectors++; if (data_out !== {COL{64'h123456789ABCDEF0}}) begin errors++; $display("FAIL abl_data: got %h want %h", data_out, {COL{64'h123456789ABCDEF0}}); end
        tick();
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abl_done_late: got %b want 0", done); end
        lb_d = 1'b0;
        $display("test_abort_last complete");
    endtask

    task automatic test_abort_idle();
        data_in = {COL{64'hCAFEBABE12345678}};
        load_en = 1'b1;
        abort   = 1'b1;
        tick();
        load_en = 1'b0;
        abort   = 1'b0;
        vectors++; if (data_out !== {COL{64'hCAFEBABE12345678}}) begin errors++; $display("FAIL abi_data: got %h want %h", data_out, {COL{64'hCAFEBABE12345678}}); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abi_busy: got %b want 0", busy); end
        $display("test_abort_idle complete");
    endtask

    task automatic test_async_reset();
        lb_d = 1'b1;
        start_pass(PAT_X, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (data_out !== '0) begin errors++; $display("FAIL arst_data: got %h want 0", data_out); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
        vectors++; if (cycle_cnt !== 6'd0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", cycle_cnt); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b want 0", busy); end
        vectors++; if (data_out !== '0) begin errors++; $display("FAIL arst_data_post: got %h want 0", data_out); end
        lb_d = 1'b0;
        $display("test_async_reset complete");
    endtask

`ifdef STATE_SHIFT_ZEROIZE_EN
    task automatic test_zeroize();
        lb_d = 1'b1;
        start_pass(PAT_X, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
        end
        zeroize = 1'b1;
        start   = 1'b1;
        tick();
        zeroize = 1'b0;
        start   = 1'b0;
        vectors++; if (data_out !== '0) begin errors++; $display("FAIL zero_data: got %h want 0", data_out); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        vectors++; if (cycle_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt: got %0d want 0", cycle_cnt); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after c%0d: done %b busy %b want 0 0", k, done, busy); end
            tick();
        end
        lb_d = 1'b0;
        $display("test_zeroize complete");
    endtask
`endif

    initial begin
        rst     = 1'b1;
        load_en = 1'b0;
        data_in = '0;
        start   = 1'b0;
        mode    = 1'b0;
        abort   = 1'b0;
        lb_1    = 1'b0;
        lb_d    = 1'b0;
`ifdef STATE_SHIFT_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        test_reset();
        test_rotate_masked();
        test_clear_unmasked();
        test_rotate_unmasked_distinct();
        test_ignore_busy();
        test_abort();
        test_abort_last();
        test_abort_idle();
        test_async_reset();
`ifdef STATE_SHIFT_ZEROIZE_EN
        test_zeroize();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
